// File: rtl/mem_access_if.sv
// ---------------------------------------------------------------------------
// mem_access_if
//   SRAM-like data bus between the load/store stage and data memory.
//   Signal names are written from the stage's point of view (_o leaves the
//   stage, _i enters it).
//
//   data_req_o     request valid
//   data_we_o      1 = write
//   data_wstrb_o   byte write strobes
//   data_addr_o    word-aligned byte address
//   data_wdata_o   write data, replicated into every lane the strobes can hit
//   data_addr_ok_i request accepted by memory
//   data_data_ok_i transaction finished, data_rdata_i valid
//   data_rdata_i   read data word
// ---------------------------------------------------------------------------
interface mem_access_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;
  logic [31:0] data_rdata_i;

  // The load/store stage drives the request side.
  modport master (
    output data_req_o, data_we_o, data_wstrb_o, data_addr_o, data_wdata_o,
    input  data_addr_ok_i, data_data_ok_i, data_rdata_i
  );

  // Memory answers the request.
  modport slave (
    input  data_req_o, data_we_o, data_wstrb_o, data_addr_o, data_wdata_o,
    output data_addr_ok_i, data_data_ok_i, data_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//   Load/store stage sitting just before the mem pass-through stage. Takes one
//   instruction per cycle from EX; non-memory ops pass straight through with a
//   one-cycle latency. Aligned loads/stores run a req/addr_ok/data_ok bus
//   transaction while stall_o holds EX. Misaligned accesses raise ale_o
//   without touching the bus. Load data is lane-selected and extended here.
//
//   clk, rst              clock, synchronous active-low reset
//   valid_i, flush_i      EX handshake and kill request
//   reg_write_*_i         ALU result / destination from EX
//   mem_*_i, store_data_i memory op description
//   stall_o               high whenever a bus transaction is in progress
//   bus                   data memory bus (master side)
//   valid_o, reg_write_*_o, ale_o   registered write-back fields for mem
// ---------------------------------------------------------------------------
module mem_access (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic [31:0]         reg_write_data_i,
  input  logic [4:0]          reg_write_addr_i,
  input  logic                reg_write_en_i,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [1:0]          mem_size_i,
  input  logic                mem_unsigned_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [31:0]         store_data_i,
  output logic                stall_o,
  mem_access_if.master        bus,
  output logic                valid_o,
  output logic [31:0]         reg_write_data_o,
  output logic [4:0]          reg_write_addr_o,
  output logic                reg_write_en_o,
  output logic                ale_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;

  // Request latched when an aligned memory op is accepted.
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_en_q, rd_en_d;

  // Registered write-back fields.
  logic        valid_q, valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic        wb_en_q, wb_en_d;
  logic        ale_q, ale_d;

  logic        misaligned_in;
  logic        in_req;
  logic        discard;
  logic [31:0] byte_lane;
  logic [31:0] half_lane;
  logic [31:0] load_val;
  logic [3:0]  strb;
  logic [31:0] wdata;

  // Alignment check on the incoming op: halves need addr[0]==0, words (and
  // the size-11 encoding, treated as word) need addr[1:0]==0.
  always_comb begin
    misaligned_in = 1'b0;
    case (mem_size_i)
      2'b00:   misaligned_in = 1'b0;
      2'b01:   misaligned_in = mem_addr_i[0];
      default: misaligned_in = (mem_addr_i[1:0] != 2'b00);
    endcase
  end

  // Load data: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    byte_lane = bus.data_rdata_i >> {addr_q[1:0], 3'b000};
    half_lane = bus.data_rdata_i >> {addr_q[1], 4'b0000};
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h000000, byte_lane[7:0]}
                                : {{24{byte_lane[7]}}, byte_lane[7:0]};
      2'b01:   load_val = uns_q ? {16'h0000, half_lane[15:0]}
                                : {{16{half_lane[15]}}, half_lane[15:0]};
      default: load_val = bus.data_rdata_i;
    endcase
  end

  // Store encoding: strobes select the lanes, data is replicated so the
  // selected lanes carry the value whatever the low address bits are.
  always_comb begin
    case (size_q)
      2'b00: begin
        strb  = 4'b0001 << addr_q[1:0];
        wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        strb  = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = sdata_q;
      end
    endcase
  end

  // Bus outputs come only from the latched request, so they hold steady for
  // the whole REQ state and read as zero everywhere else (including reset).
  always_comb begin
    in_req           = (state_q == REQ);
    bus.data_req_o   = in_req;
    bus.data_we_o    = in_req & we_q;
    bus.data_wstrb_o = (in_req && we_q) ? strb : 4'b0000;
    bus.data_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    bus.data_wdata_o = in_req ? wdata : 32'h0;
    stall_o          = (state_q != IDLE);
  end

  // A flush seen at any point after the bus accepted the request (this cycle
  // or recorded earlier in kill_q) means the result is thrown away.
  assign discard = kill_q | flush_i;

  // Next-state and write-back logic. Write-back fields default to zero so
  // valid_o and ale_o are one-cycle pulses and idle cycles read as zero.
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    rd_d      = rd_q;
    rd_en_d   = rd_en_q;
    valid_d   = 1'b0;
    wb_data_d = 32'h0;
    wb_addr_d = 5'h0;
    wb_en_d   = 1'b0;
    ale_d     = 1'b0;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (valid_i && !flush_i) begin
          if (!mem_req_i) begin
            valid_d   = 1'b1;
            wb_data_d = reg_write_data_i;
            wb_addr_d = reg_write_addr_i;
            wb_en_d   = reg_write_en_i;
          end else if (misaligned_in) begin
            valid_d   = 1'b1;
            ale_d     = 1'b1;
            wb_addr_d = reg_write_addr_i;
          end else begin
            we_d    = mem_we_i;
            size_d  = mem_size_i;
            uns_d   = mem_unsigned_i;
            addr_d  = mem_addr_i;
            sdata_d = store_data_i;
            rd_d    = reg_write_addr_i;
            rd_en_d = reg_write_en_i;
            state_d = REQ;
          end
        end
      end

      // Before acceptance a flush can simply drop the request; once
      // addr_ok is seen the handshake must run to data_ok.
      REQ: begin
        if (bus.data_addr_ok_i) begin
          if (bus.data_data_ok_i) begin
            state_d   = IDLE;
            kill_d    = 1'b0;
            valid_d   = !discard;
            wb_addr_d = discard ? 5'h0 : rd_q;
            wb_en_d   = !discard && !we_q && rd_en_q;
            wb_data_d = (discard || we_q) ? 32'h0 : load_val;
          end else begin
            state_d = WAIT;
            kill_d  = discard;
          end
        end else if (flush_i) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end

      WAIT: begin
        kill_d = discard;
        if (bus.data_data_ok_i) begin
          state_d   = IDLE;
          kill_d    = 1'b0;
          valid_d   = !discard;
          wb_addr_d = discard ? 5'h0 : rd_q;
          wb_en_d   = !discard && !we_q && rd_en_q;
          wb_data_d = (discard || we_q) ? 32'h0 : load_val;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      kill_q    <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      addr_q    <= 32'h0;
      sdata_q   <= 32'h0;
      rd_q      <= 5'h0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      wb_data_q <= 32'h0;
      wb_addr_q <= 5'h0;
      wb_en_q   <= 1'b0;
      ale_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      rd_q      <= rd_d;
      rd_en_q   <= rd_en_d;
      valid_q   <= valid_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      wb_en_q   <= wb_en_d;
      ale_q     <= ale_d;
    end
  end

  assign valid_o          = valid_q;
  assign reg_write_data_o = wb_data_q;
  assign reg_write_addr_o = wb_addr_q;
  assign reg_write_en_o   = wb_en_q;
  assign ale_o            = ale_q;

endmodule
